port_mem_writer: RTL and testbench
==================================

# port_mem_writer

Per-port ingress stage that turns one RX MAC byte stream into linked fixed-size memory blocks, feeding one slot of the shared round-robin arbiter. It does three things:
- Prefetches block addresses from the free-list path.
- Packs bytes into blocks and writes each block in its arbiter slot.
- Extracts the destination and source MAC addresses and publishes a frame descriptor (start block, addresses, `eop_o`) in the same slot as the final block write.

## Interface
- `ADDR_W`, default 8: block address width.
- `DATA_BYTES`, default 8: payload bytes per block. Must be ≥ 2×NUM_PORTS for lossless line rate.
- `CNT_W`: localparam, `$clog2(DATA_BYTES+1)`.
- `BLOCK_BITS`: localparam, `ADDR_W+2+CNT_W+8*DATA_BYTES`.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_data_i` in 8: byte.
- `rx_valid_i` in 1: byte qualifier. There is no backpressure.
- `rx_sof_i` in 1: first byte of frame.
- `rx_eof_i` in 1: last byte of frame.
- `mem_gnt_i` in 1: slot pulse from arbiter. Our write slot is the following cycle.
- `mem_we_o` out 1: block write strobe.
- `mem_addr_o` out ADDR_W: block address.
- `mem_wdata_o` out BLOCK_BITS: block contents.
- `fl_alloc_req_o` out 1: allocation request, level.
- `fl_alloc_gnt_i` in 1: allocation granted.
- `fl_alloc_block_idx_i` in ADDR_W: granted block, valid with gnt.
- `rx_mac_dst_addr_o` out 48: destination MAC.
- `rx_mac_src_addr_o` out 48: source MAC.
- `data_start_addr_o` out ADDR_W: first block of frame.
- `eop_o` out 1: descriptor valid, one cycle.
- `drop_cnt_o` out 16: see Configuration.
- `trunc_cnt_o` out 16: see Configuration.

## Operation
- **Block layout**, MSB to LSB: `next[ADDR_W]`, `last`, `err`, `count[CNT_W]`, data. Byte k occupies bits `[8k+7:8k]`. Unused bytes are 0. `next` is 0 when `last=1`.
- **Spare register** holds one prefetched address.
  - `fl_alloc_req_o` is high while the spare is empty and not in reset.
  - On `fl_alloc_gnt_i`, load `fl_alloc_block_idx_i` into the spare.
- **Assembly buffers:** two, ping-pong. A buffer takes the spare address when it receives its first byte, which empties the spare.
- **FSM: IDLE, FRAME, DROP.**
- **IDLE**
  - A valid byte without sof is discarded.
  - sof with spare valid: go to FRAME, the byte becomes byte 0, and latch `data_start_addr` = spare.
  - sof with spare empty: go to DROP and increment the drop count. Nothing is written.
- **FRAME**
  - `rx_sof_i` is ignored.
  - Bytes 0–5 form dst; byte 0 goes to `[47:40]`. Bytes 6–11 form src the same way.
  - A buffer reaching DATA_BYTES without eof requires a valid spare, which becomes its `next` and the next buffer's address.
    - If the spare is empty, or the other buffer is still pending write, the frame is truncated.
    - Truncation: close the current buffer with `last=1` and `err=1`, increment the trunc count, and go to DROP.
  - On eof: close the buffer with `last=1`; `err=1` if fewer than 12 bytes were received. Go to IDLE.
- **DROP:** discard bytes through eof, then go to IDLE. The eof byte itself is discarded.
- **Write:** a closed buffer is pending. On `mem_gnt_i` with a pending buffer, drive a one-cycle write next cycle, oldest buffer first. The buffer frees after that cycle.
- **Descriptor:** `eop_o` pulses in the same cycle as a `last=1` block write, including err frames. The descriptor registers hold their values until the next descriptor.

## Timing
- **Reset:** all outputs are 0, the FSM is in IDLE, buffers and spare are empty. Reset mid-frame abandons the frame and leaks held blocks; this is accepted.
- **fl path:** `fl_alloc_req_o` deasserts the cycle after gnt. gnt without req is ignored.
- **Write latency:** the close-to-write latency is 1 to NUM_PORTS+1 cycles.
- **Simultaneous events:**
  - A close and `mem_gnt_i` in the same cycle: write next cycle.
  - A gnt and a spare take in the same cycle: the spare stays empty and req stays high.
- A one-byte frame (sof and eof together) gives one block with `count=1`, `last=1`, `err=1`.

## Configuration
- `PORT_MEM_WRITER_STATS_EN` defined: `drop_cnt_o` and `trunc_cnt_o` are 16-bit saturating counters, reset to 0. Each increments by 1 per event at saturation below 0xFFFF.
- Undefined: both outputs are tied to 0 and the counters are not built.

## Test plan
- **Lossless 20-byte frame:** DATA_BYTES=8, spare prefilled with 0x05, allocator returns 0x06 then 0x07, gnt every 4 cycles, bytes 0x00..0x13.
  - Writes: 0x05 (`next=0x06`, count 8), 0x06 (`next=0x07`, count 8), 0x07 (`last=1`, count 4, data 0x10..0x13).
  - `eop_o` fires with the 0x07 write, `data_start_addr_o=0x05`, dst 0x000102030405, src 0x060708090A0B.
- **Free list empty at sof:** no writes, no `eop_o`, `drop_cnt_o=1`, next frame accepted after a gnt.
- **Allocator stalled mid-frame:** the first block is written with `last=1`, `err=1`, count 8; `eop_o` fires; `trunc_cnt_o=1`; remaining bytes are ignored.
- **One-byte frame 0xAA:** a single block with count 1, `last=1`, `err=1`, data byte 0 = 0xAA.
- **Reset asserted mid-frame:** all outputs are 0 asynchronously; a frame after reset release and a spare refill is stored correctly.
- **Stats compiled out:** a repeat of the drop scenario reads `drop_cnt_o=0`.

Source files
------------

// File: rtl/port_mem_writer.sv
// ============================================================================
//  Module      : port_mem_writer
//  Description : Per-port ingress stage. Packs one RX MAC byte stream into
//                linked fixed-size memory blocks written in this port's
//                arbiter slot, prefetches block addresses from the free list,
//                and publishes a frame descriptor (start block, dst/src MAC,
//                eop_o) together with the final block write of each frame.
//  Options     : PORT_MEM_WRITER_STATS_EN - builds the 16-bit saturating
//                drop/truncation counters; otherwise both read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_mem_writer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_BYTES = 8,   // >= 2 and >= 2*NUM_PORTS for line rate
  localparam int CNT_W      = $clog2(DATA_BYTES + 1),
  localparam int BLOCK_BITS = ADDR_W + 2 + CNT_W + 8 * DATA_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  rx_sof_i,
  input  logic                  rx_eof_i,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  output logic                  fl_alloc_req_o,
  input  logic                  fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]     fl_alloc_block_idx_i,
  output logic [47:0]           rx_mac_dst_addr_o,
  output logic [47:0]           rx_mac_src_addr_o,
  output logic [ADDR_W-1:0]     data_start_addr_o,
  output logic                  eop_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           trunc_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t r_state;

  // Prefetched block address
  logic              r_spare_vld;
  logic [ADDR_W-1:0] r_spare;

  // Ping-pong assembly buffers
  logic                    r_cur;      // buffer receiving bytes / next to be used
  logic                    r_rd;       // oldest closed buffer
  logic [1:0]              r_busy;     // owned by a frame (assembling or pending)
  logic [1:0]              r_pend;     // closed, waiting for (or in) its write
  logic [1:0]              r_last;
  logic [1:0]              r_err;
  logic [ADDR_W-1:0]       r_addr   [2];
  logic [ADDR_W-1:0]       r_next   [2];
  logic [CNT_W-1:0]        r_cnt    [2];
  logic [8*DATA_BYTES-1:0] r_data   [2];
  logic [ADDR_W-1:0]       r_bstart [2];
  logic [47:0]             r_bdst   [2];
  logic [47:0]             r_bsrc   [2];

  // Write engine
  logic r_wr_go;
  logic r_wr_idx;

  // Per-frame header capture
  logic [ADDR_W-1:0] r_start;
  logic [47:0]       r_dst;
  logic [47:0]       r_src;
  logic [3:0]        r_nbytes;   // bytes seen so far, saturates at 12

  // Descriptor held between frames
  logic [ADDR_W-1:0] r_hold_start;
  logic [47:0]       r_hold_dst;
  logic [47:0]       r_hold_src;

  logic              w_other;
  logic [CNT_W-1:0]  w_cur_cnt;
  logic              w_full;
  logic              w_sof_hit;
  logic              w_start_ok;
  logic              w_in_frame;
  logic              w_accept;
  logic              w_fill;
  logic              w_link;
  logic              w_trunc;
  logic              w_eof_close;
  logic              w_close;
  logic              w_close_last;
  logic              w_close_err;
  logic              w_take;
  logic              w_take_idx;
  logic              w_cand;
  logic              w_cand_ready;
  logic              w_issue;
  logic [3:0]        w_idx;
  logic [47:0]       w_dst_nxt;
  logic [47:0]       w_src_nxt;

  assign w_other   = ~r_cur;
  assign w_cur_cnt = r_cnt[r_cur];
  assign w_full    = (w_cur_cnt == CNT_W'(DATA_BYTES - 1));

  // A new frame needs both a prefetched address and a free buffer; a frame
  // that finds the next buffer still queued for writing is dropped rather
  // than overwriting unwritten data.
  assign w_sof_hit  = rx_valid_i && rx_sof_i && (r_state == S_IDLE);
  assign w_start_ok = w_sof_hit && r_spare_vld && !r_busy[r_cur];
  assign w_in_frame = rx_valid_i && (r_state == S_FRAME);
  assign w_accept   = w_start_ok || w_in_frame;

  // Filling the last byte slot without eof: chain to a new block if possible
  assign w_fill      = w_accept && !rx_eof_i && w_full;
  assign w_link      = w_fill && r_spare_vld && !w_start_ok && !r_busy[w_other];
  assign w_trunc     = w_fill && !w_link;
  assign w_eof_close = w_accept && rx_eof_i;

  assign w_close      = w_eof_close || w_link || w_trunc;
  assign w_close_last = w_eof_close || w_trunc;
  assign w_close_err  = w_trunc || (w_eof_close && (w_idx < 4'd11));

  assign w_take     = w_start_ok || w_link;
  assign w_take_idx = w_start_ok ? r_cur : w_other;

  // While a write is in progress its buffer is still pending, so the next
  // candidate is the other one.
  assign w_cand       = r_rd ^ r_wr_go;
  assign w_cand_ready = r_pend[w_cand] || (w_close && (r_cur == w_cand));
  assign w_issue      = mem_gnt_i && w_cand_ready;

  // Header bytes after the current byte: 0-5 dst, 6-11 src, MSB first
  always_comb begin
    w_idx     = w_start_ok ? 4'd0 : r_nbytes;
    w_dst_nxt = w_start_ok ? 48'h0 : r_dst;
    w_src_nxt = w_start_ok ? 48'h0 : r_src;
    if (w_accept) begin
      if (w_idx < 4'd6) begin
        w_dst_nxt[8*(5 - int'(w_idx)) +: 8] = rx_data_i;
      end else if (w_idx < 4'd12) begin
        w_src_nxt[8*(11 - int'(w_idx)) +: 8] = rx_data_i;
      end
    end
  end

  // Spare address register: filled by the free list, emptied by a take
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spare_vld <= 1'b0;
      r_spare     <= '0;
    end else if (w_take) begin
      r_spare_vld <= 1'b0;
    end else if (fl_alloc_gnt_i && !r_spare_vld) begin
      r_spare_vld <= 1'b1;
      r_spare     <= fl_alloc_block_idx_i;
    end
  end

  assign fl_alloc_req_o = ~r_spare_vld & ~rst;

  // Frame-level state machine and header capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_start  <= '0;
      r_dst    <= '0;
      r_src    <= '0;
      r_nbytes <= '0;
    end else begin
      if (w_accept) begin
        r_dst    <= w_dst_nxt;
        r_src    <= w_src_nxt;
        r_nbytes <= (w_idx == 4'd12) ? 4'd12 : w_idx + 4'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_sof_hit) begin
            if (w_start_ok) begin
              r_start <= r_spare;
            end
            if (rx_eof_i) begin
              r_state <= S_IDLE;
            end else if (w_start_ok) begin
              r_state <= S_FRAME;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_FRAME: begin
          if (w_eof_close) begin
            r_state <= S_IDLE;
          end else if (w_trunc) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (rx_valid_i && rx_eof_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer ownership, byte packing, closing and slot writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur    <= 1'b0;
      r_rd     <= 1'b0;
      r_wr_go  <= 1'b0;
      r_wr_idx <= 1'b0;
      r_busy   <= '0;
      r_pend   <= '0;
      r_last   <= '0;
      r_err    <= '0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]   <= '0;
        r_next[i]   <= '0;
        r_cnt[i]    <= '0;
        r_data[i]   <= '0;
        r_bstart[i] <= '0;
        r_bdst[i]   <= '0;
        r_bsrc[i]   <= '0;
      end
    end else begin
      r_wr_go <= w_issue;
      if (w_issue) begin
        r_wr_idx <= w_cand;
      end
      // Release the buffer at the end of its write cycle; clearing the data
      // keeps unused bytes of the next block at zero.
      if (r_wr_go) begin
        r_busy[r_wr_idx] <= 1'b0;
        r_pend[r_wr_idx] <= 1'b0;
        r_last[r_wr_idx] <= 1'b0;
        r_err[r_wr_idx]  <= 1'b0;
        r_cnt[r_wr_idx]  <= '0;
        r_data[r_wr_idx] <= '0;
        r_rd             <= ~r_wr_idx;
      end
      if (w_take) begin
        r_busy[w_take_idx] <= 1'b1;
        r_addr[w_take_idx] <= r_spare;
      end
      if (w_accept) begin
        r_data[r_cur][8*int'(w_cur_cnt) +: 8] <= rx_data_i;
        r_cnt[r_cur] <= w_cur_cnt + CNT_W'(1);
      end
      if (w_close) begin
        r_pend[r_cur]   <= 1'b1;
        r_last[r_cur]   <= w_close_last;
        r_err[r_cur]    <= w_close_err;
        r_next[r_cur]   <= w_link ? r_spare : '0;
        r_bstart[r_cur] <= w_start_ok ? r_spare : r_start;
        r_bdst[r_cur]   <= w_dst_nxt;
        r_bsrc[r_cur]   <= w_src_nxt;
        r_cur           <= ~r_cur;
      end
    end
  end

  assign mem_we_o    = r_wr_go;
  assign mem_addr_o  = r_wr_go ? r_addr[r_wr_idx] : '0;
  assign mem_wdata_o = r_wr_go ? {r_next[r_wr_idx], r_last[r_wr_idx], r_err[r_wr_idx],
                                  r_cnt[r_wr_idx], r_data[r_wr_idx]} : '0;
  assign eop_o       = r_wr_go & r_last[r_wr_idx];

  // The descriptor is presented live during the final write, then held
  assign data_start_addr_o = eop_o ? r_bstart[r_wr_idx] : r_hold_start;
  assign rx_mac_dst_addr_o = eop_o ? r_bdst[r_wr_idx]   : r_hold_dst;
  assign rx_mac_src_addr_o = eop_o ? r_bsrc[r_wr_idx]   : r_hold_src;

  // Keep the last published descriptor stable until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_start <= '0;
      r_hold_dst   <= '0;
      r_hold_src   <= '0;
    end else if (eop_o) begin
      r_hold_start <= r_bstart[r_wr_idx];
      r_hold_dst   <= r_bdst[r_wr_idx];
      r_hold_src   <= r_bsrc[r_wr_idx];
    end
  end

`ifdef PORT_MEM_WRITER_STATS_EN
  logic        w_sof_drop;
  logic [15:0] r_drop_cnt;
  logic [15:0] r_trunc_cnt;

  assign w_sof_drop = w_sof_hit && !w_start_ok;

  // Saturating event counters for dropped and truncated frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_sof_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_trunc && (r_trunc_cnt != 16'hFFFF)) begin
        r_trunc_cnt <= r_trunc_cnt + 16'd1;
      end
    end
  end

  assign drop_cnt_o  = r_drop_cnt;
  assign trunc_cnt_o = r_trunc_cnt;
`else
  assign drop_cnt_o  = '0;
  assign trunc_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_port_mem_writer.sv
// ============================================================================
//  Module      : tb_port_mem_writer
//  Description : Directed self-checking bench for port_mem_writer
//                (ADDR_W=8, DATA_BYTES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_port_mem_writer;

  localparam int ADDR_W     = 8;
  localparam int DATA_BYTES = 8;
  localparam int BLOCK_BITS = 78;

`ifdef PORT_MEM_WRITER_STATS_EN
  localparam logic [15:0] EXP_EVT = 16'd1;
`else
  localparam logic [15:0] EXP_EVT = 16'd0;
`endif

  logic                  clk;
  logic                  rst;
  logic [7:0]            rx_data_i;
  logic                  rx_valid_i;
  logic                  rx_sof_i;
  logic                  rx_eof_i;
  logic                  mem_gnt_i;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [BLOCK_BITS-1:0] mem_wdata_o;
  logic                  fl_alloc_req_o;
  logic                  fl_alloc_gnt_i;
  logic [ADDR_W-1:0]     fl_alloc_block_idx_i;
  logic [47:0]           rx_mac_dst_addr_o;
  logic [47:0]           rx_mac_src_addr_o;
  logic [ADDR_W-1:0]     data_start_addr_o;
  logic                  eop_o;
  logic [15:0]           drop_cnt_o;
  logic [15:0]           trunc_cnt_o;

  port_mem_writer #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_data_i            (rx_data_i),
    .rx_valid_i           (rx_valid_i),
    .rx_sof_i             (rx_sof_i),
    .rx_eof_i             (rx_eof_i),
    .mem_gnt_i            (mem_gnt_i),
    .mem_we_o             (mem_we_o),
    .mem_addr_o           (mem_addr_o),
    .mem_wdata_o          (mem_wdata_o),
    .fl_alloc_req_o       (fl_alloc_req_o),
    .fl_alloc_gnt_i       (fl_alloc_gnt_i),
    .fl_alloc_block_idx_i (fl_alloc_block_idx_i),
    .rx_mac_dst_addr_o    (rx_mac_dst_addr_o),
    .rx_mac_src_addr_o    (rx_mac_src_addr_o),
    .data_start_addr_o    (data_start_addr_o),
    .eop_o                (eop_o),
    .drop_cnt_o           (drop_cnt_o),
    .trunc_cnt_o          (trunc_cnt_o)
  );

  int n_checks;
  int n_pass;

  logic [ADDR_W-1:0]     rec_addr[$];
  logic [BLOCK_BITS-1:0] rec_data[$];
  logic                  rec_eop[$];
  int                    eop_cnt;
  int                    stray_eop;
  logic [ADDR_W-1:0]     eop_start;
  logic [47:0]           eop_dst;
  logic [47:0]           eop_src;

  logic [7:0] alloc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arbiter: slot pulse every 4 cycles
  initial begin
    int k;
    k = 0;
    mem_gnt_i = 1'b0;
    forever begin
      @(negedge clk);
      mem_gnt_i = (k % 4 == 0);
      k++;
    end
  end

  // Free-list allocator: grants queued addresses while req is high
  initial begin
    fl_alloc_gnt_i = 1'b0;
    fl_alloc_block_idx_i = '0;
    forever begin
      @(negedge clk);
      if (fl_alloc_req_o && alloc_q.size() > 0) begin
        fl_alloc_gnt_i = 1'b1;
        fl_alloc_block_idx_i = alloc_q.pop_front();
      end else begin
        fl_alloc_gnt_i = 1'b0;
        fl_alloc_block_idx_i = '0;
      end
    end
  end

  // Record every block write and descriptor
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we_o) begin
        rec_addr.push_back(mem_addr_o);
        rec_data.push_back(mem_wdata_o);
        rec_eop.push_back(eop_o);
      end
      if (eop_o) begin
        eop_cnt++;
        eop_start = data_start_addr_o;
        eop_dst   = rx_mac_dst_addr_o;
        eop_src   = rx_mac_src_addr_o;
        if (!mem_we_o) stray_eop++;
      end
    end
  end

  task automatic clear_rec();
    rec_addr.delete();
    rec_data.delete();
    rec_eop.delete();
    eop_cnt = 0;
    stray_eop = 0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base, input bit with_eof);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_valid_i = 1'b1;
      rx_data_i  = base + 8'(k);
      rx_sof_i   = (k == 0);
      rx_eof_i   = with_eof && (k == n - 1);
    end
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_sof_i   = 1'b0;
    rx_eof_i   = 1'b0;
    rx_data_i  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push one address and wait (bounded) for it to land in the spare
  task automatic refill(input logic [7:0] a, input string tag);
    bit got;
    got = 1'b0;
    alloc_q.push_back(a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!fl_alloc_req_o) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (got !== 1'b1) $display("FAIL %s_refill timeout: req still %b, want 0", tag, fl_alloc_req_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid_i = 1'b0; rx_sof_i = 1'b0; rx_eof_i = 1'b0; rx_data_i = '0;
    idle(3);
    n_checks++;
    if ({mem_we_o, eop_o, fl_alloc_req_o} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {mem_we_o, eop_o, fl_alloc_req_o});
    else n_pass++;
    rst = 1'b0;
    idle(2);
    n_checks++;
    if (fl_alloc_req_o !== 1'b1) $display("FAIL reset_req got %b want 1", fl_alloc_req_o);
    else n_pass++;
    n_checks++;
    if ({drop_cnt_o, trunc_cnt_o, data_start_addr_o} !== 40'h0) $display("FAIL reset_outs got %h want 0", {drop_cnt_o, trunc_cnt_o, data_start_addr_o});
    else n_pass++;
  endtask

  task automatic test_lossless();
    logic [BLOCK_BITS-1:0] e0, e1, e2;
    e0 = {8'h06, 1'b0, 1'b0, 4'd8, 64'h0706050403020100};
    e1 = {8'h07, 1'b0, 1'b0, 4'd8, 64'h0F0E0D0C0B0A0908};
    e2 = {8'h00, 1'b1, 1'b0, 4'd4, 64'h0000000013121110};
    refill(8'h05, "lossless");
    alloc_q.push_back(8'h06);
    alloc_q.push_back(8'h07);
    clear_rec();
    send_bytes(20, 8'h00, 1'b1);
    idle(24);
    n_checks++;
    if (rec_addr.size() !== 3) $display("FAIL lossless_nwrites got %0d want 3", rec_addr.size());
    else n_pass++;
    n_checks++;
    if ({rec_addr[0], rec_addr[1], rec_addr[2]} !== 24'h050607) $display("FAIL lossless_addrs got %h want 050607", {rec_addr[0], rec_addr[1], rec_addr[2]});
    else n_pass++;
    n_checks++;
    if (rec_data[0] !== e0) $display("FAIL lossless_blk0 got %h want %h", rec_data[0], e0);
    else n_pass++;
    n_checks++;
    if (rec_data[1] !== e1) $display("FAIL lossless_blk1 got %h want %h", rec_data[1], e1);
    else n_pass++;
    n_checks++;
    if (rec_data[2] !== e2) $display("FAIL lossless_blk2 got %h want %h", rec_data[2], e2);
    else n_pass++;
    n_checks++;
    if ({rec_eop[0], rec_eop[1], rec_eop[2]} !== 3'b001 || eop_cnt != 1 || stray_eop != 0)
      $display("FAIL lossless_eop got flags %b cnt %0d stray %0d want 001/1/0", {rec_eop[0], rec_eop[1], rec_eop[2]}, eop_cnt, stray_eop);
    else n_pass++;
    n_checks++;
    if (eop_start !== 8'h05) $display("FAIL lossless_start got %h want 05", eop_start);
    else n_pass++;
    n_checks++;
    if (eop_dst !== 48'h000102030405) $display("FAIL lossless_dst got %h want 000102030405", eop_dst);
    else n_pass++;
    n_checks++;
    if (eop_src !== 48'h060708090A0B) $display("FAIL lossless_src got %h want 060708090a0b", eop_src);
    else n_pass++;
    n_checks++;
    if (data_start_addr_o !== 8'h05) $display("FAIL lossless_hold got %h want 05", data_start_addr_o);
    else n_pass++;
  endtask

  task automatic test_drop();
    logic [BLOCK_BITS-1:0] e0;
    e0 = {8'h00, 1'b1, 1'b1, 4'd6, 64'h0000454443424140};
    clear_rec();
    send_bytes(5, 8'h80, 1'b1);
    idle(12);
    n_checks++;
    if (rec_addr.size() !== 0 || eop_cnt != 0) $display("FAIL drop_nowrite got writes %0d eops %0d want 0/0", rec_addr.size(), eop_cnt);
    else n_pass++;
    n_checks++;
    if (drop_cnt_o !== EXP_EVT) $display("FAIL drop_cnt got %0d want %0d", drop_cnt_o, EXP_EVT);
    else n_pass++;
    refill(8'h20, "drop");
    clear_rec();
    send_bytes(6, 8'h40, 1'b1);
    idle(16);
    n_checks++;
    if (rec_addr.size() !== 1 || rec_addr[0] !== 8'h20) $display("FAIL drop_next_addr got n=%0d addr %h want 1/20", rec_addr.size(), rec_addr[0]);
    else n_pass++;
    n_checks++;
    if (rec_data[0] !== e0) $display("FAIL drop_next_blk got %h want %h", rec_data[0], e0);
    else n_pass++;
    n_checks++;
    if (eop_cnt != 1 || eop_start !== 8'h20 || eop_dst !== 48'h404142434445 || eop_src !== 48'h0)
      $display("FAIL drop_next_desc got eops %0d start %h dst %h src %h", eop_cnt, eop_start, eop_dst, eop_src);
    else n_pass++;
  endtask

  task automatic test_trunc();
    logic [BLOCK_BITS-1:0] e0;
    e0 = {8'h00, 1'b1, 1'b1, 4'd8, 64'h5756555453525150};
    refill(8'h30, "trunc");
    clear_rec();
    send_bytes(20, 8'h50, 1'b1);
    idle(20);
    n_checks++;
    if (rec_addr.size() !== 1 || rec_addr[0] !== 8'h30) $display("FAIL trunc_addr got n=%0d addr %h want 1/30", rec_addr.size(), rec_addr[0]);
    else n_pass++;
    n_checks++;
    if (rec_data[0] !== e0) $display("FAIL trunc_blk got %h want %h", rec_data[0], e0);
    else n_pass++;
    n_checks++;
    if (eop_cnt != 1 || stray_eop != 0) $display("FAIL trunc_eop got %0d stray %0d want 1/0", eop_cnt, stray_eop);
    else n_pass++;
    n_checks++;
    if (trunc_cnt_o !== EXP_EVT) $display("FAIL trunc_cnt got %0d want %0d", trunc_cnt_o, EXP_EVT);
    else n_pass++;
    n_checks++;
    if (eop_dst !== 48'h505152535455 || eop_src !== 48'h565700000000) $display("FAIL trunc_macs got %h %h want 505152535455 565700000000", eop_dst, eop_src);
    else n_pass++;
  endtask

  task automatic test_one_byte();
    logic [BLOCK_BITS-1:0] e0;
    e0 = {8'h00, 1'b1, 1'b1, 4'd1, 64'h00000000000000AA};
    refill(8'h40, "onebyte");
    clear_rec();
    send_bytes(1, 8'hAA, 1'b1);
    idle(12);
    n_checks++;
    if (rec_addr.size() !== 1 || rec_addr[0] !== 8'h40) $display("FAIL onebyte_addr got n=%0d addr %h want 1/40", rec_addr.size(), rec_addr[0]);
    else n_pass++;
    n_checks++;
    if (rec_data[0] !== e0) $display("FAIL onebyte_blk got %h want %h", rec_data[0], e0);
    else n_pass++;
    n_checks++;
    if (eop_cnt != 1 || eop_dst !== 48'hAA0000000000 || eop_start !== 8'h40) $display("FAIL onebyte_desc got eops %0d dst %h start %h", eop_cnt, eop_dst, eop_start);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [BLOCK_BITS-1:0] e0;
    e0 = {8'h00, 1'b1, 1'b1, 4'd6, 64'h0000757473727170};
    refill(8'h50, "rstmid");
    send_bytes(4, 8'h10, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_we_o, eop_o, fl_alloc_req_o, mem_addr_o} !== 11'h0 || mem_wdata_o !== '0) $display("FAIL rstmid_mem got we %b eop %b req %b addr %h", mem_we_o, eop_o, fl_alloc_req_o, mem_addr_o);
    else n_pass++;
    n_checks++;
    if ({rx_mac_dst_addr_o, rx_mac_src_addr_o, data_start_addr_o} !== 104'h0) $display("FAIL rstmid_desc got %h %h %h want 0", rx_mac_dst_addr_o, rx_mac_src_addr_o, data_start_addr_o);
    else n_pass++;
    n_checks++;
    if ({drop_cnt_o, trunc_cnt_o} !== 32'h0) $display("FAIL rstmid_cnt got %h want 0", {drop_cnt_o, trunc_cnt_o});
    else n_pass++;
    idle(2);
    rst = 1'b0;
    refill(8'h60, "rstmid");
    clear_rec();
    send_bytes(6, 8'h70, 1'b1);
    idle(16);
    n_checks++;
    if (rec_addr.size() !== 1 || rec_addr[0] !== 8'h60) $display("FAIL rstmid_addr got n=%0d addr %h want 1/60", rec_addr.size(), rec_addr[0]);
    else n_pass++;
    n_checks++;
    if (rec_data[0] !== e0) $display("FAIL rstmid_blk got %h want %h", rec_data[0], e0);
    else n_pass++;
    n_checks++;
    if (eop_cnt != 1 || eop_start !== 8'h60) $display("FAIL rstmid_desc2 got eops %0d start %h want 1/60", eop_cnt, eop_start);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    eop_cnt = 0;
    stray_eop = 0;
    eop_start = '0;
    eop_dst = '0;
    eop_src = '0;
    test_reset();
    test_lossless();
    test_drop();
    test_trunc();
    test_one_byte();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
